// File: rtl/regfile_read_stage.sv
// Decode-stage register read: operand select with write-back bypass and a zero
// register, ID/EX capture with stall/flush, and load-use bubble insertion.
module regfile_read_stage #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned NREGS = 32,
  parameter int unsigned CNTW  = 32,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] regs [NREGS],
  input  logic [AW-1:0]    rn_addr,
  input  logic [AW-1:0]    rm_addr,
  input  logic [AW-1:0]    rd_addr,
  input  logic             reg_write_in,
  input  logic             mem_read_in,
  input  logic             valid_in,
  input  logic             stall_in,
  input  logic             flush,
  input  logic             wb_en,
  input  logic [AW-1:0]    wb_addr,
  input  logic [WIDTH-1:0] wb_data,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic [AW-1:0]    rd_out,
  output logic             reg_write_out,
  output logic             mem_read_out,
  output logic             valid_out,
  output logic             hazard_stall,
  output logic [CNTW-1:0]  bubble_count
);

  localparam logic [AW-1:0] ZERO_REG = AW'(NREGS - 1);

  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic             rw_q, rw_d, mr_q, mr_d, v_q, v_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] op_a, op_b;
  logic             haz;

  // Zero register always reads 0; a same-cycle write-back to any other register is forwarded.
  function automatic logic [WIDTH-1:0] sel_operand(
    input logic [AW-1:0]    addr,
    input logic [WIDTH-1:0] rdata,
    input logic             en,
    input logic [AW-1:0]    waddr,
    input logic [WIDTH-1:0] wdata
  );
    if (addr == ZERO_REG)               return '0;
    else if (en && (waddr == addr))     return wdata;
    else                                return rdata;
  endfunction

  always_comb begin
    op_a = sel_operand(rn_addr, regs[rn_addr], wb_en, wb_addr, wb_data);
    op_b = sel_operand(rm_addr, regs[rm_addr], wb_en, wb_addr, wb_data);
    haz  = v_q & mr_q & (rd_q != ZERO_REG) & valid_in
           & ((rd_q == rn_addr) | (rd_q == rm_addr));
    hazard_stall = haz & ~flush;
  end

  // Next-state: flush beats stall beats hazard bubble beats normal capture.
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    rd_d  = rd_q;
    rw_d  = rw_q;
    mr_d  = mr_q;
    v_d   = v_q;
    cnt_d = cnt_q;
    if (flush || (!stall_in && haz)) begin
      a_d  = '0;
      b_d  = '0;
      rd_d = '0;
      rw_d = 1'b0;
      mr_d = 1'b0;
      v_d  = 1'b0;
      if (!flush && !(&cnt_q)) cnt_d = cnt_q + CNTW'(1);
    end else if (!stall_in) begin
      a_d  = op_a;
      b_d  = op_b;
      rd_d = rd_addr;
      v_d  = valid_in;
      rw_d = reg_write_in & valid_in;
      mr_d = mem_read_in & valid_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q   <= '0;
      b_q   <= '0;
      rd_q  <= '0;
      rw_q  <= 1'b0;
      mr_q  <= 1'b0;
      v_q   <= 1'b0;
      cnt_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      rd_q  <= rd_d;
      rw_q  <= rw_d;
      mr_q  <= mr_d;
      v_q   <= v_d;
      cnt_q <= cnt_d;
    end
  end

  assign a_out         = a_q;
  assign b_out         = b_q;
  assign rd_out        = rd_q;
  assign reg_write_out = rw_q;
  assign mem_read_out  = mr_q;
  assign valid_out     = v_q;
  assign bubble_count  = cnt_q;

endmodule
